hit_judge: RTL and testbench
============================

# hit_judge

Round controller that sits directly downstream of the target generator and closes the game loop. It compares the player cursor against the current target when the player fires, or when a per-round timer expires. It then issues a one-cycle `result_valid` pulse, which the target generator consumes to produce the next target. It also keeps the score, the miss count and the game-over status.

## Interface
- `COORD_W`, 5: width of the target and cursor coordinates.
- `SCORE_W`, 8: width of the `score` counter; saturates at its maximum.
- `HIT_RADIUS`, 1: maximum per-axis distance that counts as a hit.
- `TIMEOUT_CYCLES`, 1000: cycles allowed per round before a forced miss; must be ≥2.
- `MAX_MISSES`, 3: miss count that ends the game; must be ≥1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets all state.
- `target_x`, `target_y` in COORD_W: current target from the target generator.
- `cursor_x`, `cursor_y` in COORD_W: current player position.
- `fire` in 1: level input, already synchronised; only its rising edge is used.
- `result_valid` out 1: one-cycle pulse, one per judged round.
- `hit` out 1: outcome of the round; meaningful only while `result_valid` is high.
- `score` out SCORE_W: number of hits.
- `misses` out 2+: number of misses, sized to hold MAX_MISSES.
- `round_active` out 1: high in state ARMED.
- `game_over` out 1: high in state OVER.

## Operation
- Edge detect: register `fire_q` each cycle. `fire_rise = fire & ~fire_q`. `fire_q` resets to 0.
- Hit test:
  - `dx = |cursor_x − target_x|` and `dy = |cursor_y − target_y|`, computed as unsigned magnitudes with no wrap. Example: 0 vs 31 gives 31.
  - Hit when `dx ≤ HIT_RADIUS` and `dy ≤ HIT_RADIUS`.
- States:
  - IDLE (reset state): wait for `fire_rise`, then go to SETTLE. No result is produced.
  - SETTLE: exactly 1 cycle; clear the round timer; go to ARMED. This cycle lets the new target propagate.
  - ARMED:
    - The timer increments each cycle.
    - On `fire_rise`: latch the hit test using the inputs of that cycle, then go to RESULT.
    - Else, when the timer equals TIMEOUT_CYCLES−1: latch a miss, then go to RESULT.
    - `fire_rise` and timeout in the same cycle: fire wins and is judged normally.
  - RESULT: exactly 1 cycle.
    - `result_valid=1` and `hit` equals the latched value.
    - On a hit, `score` increments, holding at 2^SCORE_W−1.
    - On a miss, `misses` increments.
    - If the updated `misses` equals MAX_MISSES, go to OVER; otherwise go to SETTLE.
  - OVER: outputs hold. On `fire_rise`, clear `score` and `misses`, then go to SETTLE. No `result_valid` is issued on restart.
- `fire_rise` in SETTLE or RESULT is ignored; it is not queued.
- `score` and `misses` change only in RESULT, or on the OVER restart.

## Timing
- Reset values: `result_valid=0`, `hit=0`, `score=0`, `misses=0`, `round_active=0`, `game_over=0`; state IDLE; timer 0.
- Reset mid-round (any state) returns all of the above to reset values on the next rising edge. A pending result is discarded.
- Fire latency: `fire_rise` sampled at edge N → `result_valid` high during cycle N+1.
- Round cadence after a result:
  - RESULT at cycle R, SETTLE at R+1, ARMED from R+2.
  - The target generator updates at the edge ending cycle R, so the target is stable by R+1.
- Timeout: the first ARMED cycle has timer 0. With no fire, `result_valid` rises in cycle TIMEOUT_CYCLES after ARMED entry.
- `score` and `misses` show their new values in the cycle after RESULT.
- `game_over` rises in that same cycle.
- `round_active` is registered from the state and equals (state==ARMED).

## Test plan
Bench parameters: `TIMEOUT_CYCLES=16`, `HIT_RADIUS=1`, `MAX_MISSES=3`.

1. Reset held low 5 cycles, then released → all outputs 0 and state IDLE. A `fire` pulse → `round_active=1` two cycles later; no `result_valid`.
2. Target (10,10), cursor (11,9), fire rise → `result_valid`=1 for exactly 1 cycle the next cycle with `hit=1`; `score` goes 0→1.
3. Target (10,10), cursor (12,10), fire → `hit=0`, `misses=1`. Target (0,0), cursor (31,31) → miss; there is no wrap-around.
4. No fire for 16 ARMED cycles → `result_valid` with `hit=0` in ARMED cycle 16. The same round with fire on timer=15 → judged by position instead.
5. Three misses → `game_over=1` and no further `result_valid`. A fire → `score=0`, `misses=0`, `round_active=1` two cycles later.
6. Cases to cover:
   - Fire held high across rounds → only one judgment.
   - Fire rise in RESULT → ignored.
   - `reset=0` asserted mid-ARMED with the timer at 8 → all outputs 0 the next cycle.
   - `score` forced to saturate (SCORE_W=2, 4 hits) → holds at 3.

Source files
------------

// File: rtl/hit_judge_if.sv
// Purpose : bundle between the game-side logic (targets, cursor, fire button)
//           and the hit_judge round controller.
// Ports   : master drives target/cursor/fire and observes the round results;
//           slave (hit_judge) consumes target/cursor/fire and drives
//           result_valid, hit, score, misses, round_active and game_over.
// MISS_W must match the width hit_judge derives from MAX_MISSES
// (max(2, clog2(MAX_MISSES+1))).
interface hit_judge_if #(
  parameter int COORD_W = 5,
  parameter int SCORE_W = 8,
  parameter int MISS_W  = 2
);

  // Game-side inputs to the judge
  logic [COORD_W-1:0] target_x;
  logic [COORD_W-1:0] target_y;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               fire;

  // Round outputs from the judge
  logic               result_valid;
  logic               hit;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               round_active;
  logic               game_over;

  modport master (
    output target_x, target_y, cursor_x, cursor_y, fire,
    input  result_valid, hit, score, misses, round_active, game_over
  );

  modport slave (
    input  target_x, target_y, cursor_x, cursor_y, fire,
    output result_valid, hit, score, misses, round_active, game_over
  );

endinterface

// File: rtl/hit_judge.sv
// Purpose : round controller; judges cursor vs target on a fire rising edge or
//           on round timeout, keeps score / miss count / game-over status.
// Latency : fire rise sampled at edge N -> result_valid pulse in cycle N+1;
//           score/misses/game_over update in the cycle after the pulse.
// Backpr. : none; result_valid is a one-cycle pulse that cannot be stalled,
//           and fire rises outside IDLE/ARMED/OVER are dropped, not queued.
// Ports   : clk, reset (synchronous, active-low); jif (slave modport) carries
//           target_x/y, cursor_x/y, fire in and result_valid, hit, score,
//           misses, round_active, game_over out.
// Parameter constraints: TIMEOUT_CYCLES >= 2, MAX_MISSES >= 1.
module hit_judge #(
  parameter int COORD_W        = 5,
  parameter int SCORE_W        = 8,
  parameter int HIT_RADIUS     = 1,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_MISSES     = 3
) (
  input  logic        clk,
  input  logic        reset,
  hit_judge_if.slave  jif
);

  // Miss counter holds 0..MAX_MISSES and is never narrower than 2 bits.
  localparam int MISS_BITS = $clog2(MAX_MISSES + 1);
  localparam int MISS_W    = (MISS_BITS < 2) ? 2 : MISS_BITS;

  // Round timer counts 0..TIMEOUT_CYCLES-1 while ARMED.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_TOP = {SCORE_W{1'b1}};
  localparam int unsigned        RADIUS    = HIT_RADIUS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARMED,
    S_RESULT,
    S_OVER
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_q,        state_d;
  logic [TMR_W-1:0]   timer_q,        timer_d;
  logic               hit_q,          hit_d;
  logic               result_valid_q, result_valid_d;
  logic [SCORE_W-1:0] score_q,        score_d;
  logic [MISS_W-1:0]  misses_q,       misses_d;
  logic               round_active_q, round_active_d;
  logic               game_over_q,    game_over_d;
  logic               fire_q;

  // ---------------------------------------------------------------------------
  // Fire edge detect and hit test
  // ---------------------------------------------------------------------------
  logic               fire_rise;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               in_radius;
  logic [MISS_W-1:0]  misses_inc;

  assign fire_rise = jif.fire & ~fire_q;

  // Subtract the smaller from the larger so the magnitude never wraps:
  // 0 vs 31 gives 31, not 1.
  assign dx = (jif.cursor_x >= jif.target_x) ? (jif.cursor_x - jif.target_x)
                                             : (jif.target_x - jif.cursor_x);
  assign dy = (jif.cursor_y >= jif.target_y) ? (jif.cursor_y - jif.target_y)
                                             : (jif.target_y - jif.cursor_y);

  assign in_radius = (32'(dx) <= RADIUS) && (32'(dy) <= RADIUS);

  assign misses_inc = misses_q + MISS_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hit_d    = hit_q;
    score_d  = score_q;
    misses_d = misses_q;

    case (state_q)
      S_IDLE: begin
        if (fire_rise) begin
          state_d = S_SETTLE;
        end
      end

      // One dead cycle so the target generator's new target is stable before
      // the player can be judged against it.
      S_SETTLE: begin
        timer_d = '0;
        state_d = S_ARMED;
      end

      // A fire in the timeout cycle takes priority and is judged on position.
      S_ARMED: begin
        timer_d = timer_q + TMR_W'(1);
        if (fire_rise) begin
          hit_d   = in_radius;
          state_d = S_RESULT;
        end else if (timer_q == TMR_LAST) begin
          hit_d   = 1'b0;
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        if (hit_q) begin
          if (score_q != SCORE_TOP) begin
            score_d = score_q + SCORE_W'(1);
          end
          state_d = S_SETTLE;
        end else begin
          misses_d = misses_inc;
          state_d  = (misses_inc == MISS_MAX) ? S_OVER : S_SETTLE;
        end
      end

      // Restart goes straight to SETTLE without reporting a result.
      S_OVER: begin
        if (fire_rise) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = S_SETTLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they line up
    // exactly with the state they describe.
    result_valid_d = (state_d == S_RESULT);
    round_active_d = (state_d == S_ARMED);
    game_over_d    = (state_d == S_OVER);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      hit_q          <= 1'b0;
      result_valid_q <= 1'b0;
      score_q        <= '0;
      misses_q       <= '0;
      round_active_q <= 1'b0;
      game_over_q    <= 1'b0;
      fire_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      hit_q          <= hit_d;
      result_valid_q <= result_valid_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      round_active_q <= round_active_d;
      game_over_q    <= game_over_d;
      fire_q         <= jif.fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign jif.result_valid = result_valid_q;
  assign jif.hit          = hit_q;
  assign jif.score        = score_q;
  assign jif.misses       = misses_q;
  assign jif.round_active = round_active_q;
  assign jif.game_over    = game_over_q;

endmodule

// File: tb/tb_hit_judge.sv
// Purpose : self-checking bench for hit_judge (SCORE_W=2 so saturation is
//           reachable, TIMEOUT_CYCLES=16, HIT_RADIUS=1, MAX_MISSES=3).
// Ports   : none; drives the interface directly and checks results through a
//           queue of expected hit values plus per-round expected counters.
module tb_hit_judge;

  localparam int COORD_W = 5;
  localparam int SCORE_W = 2;
  localparam int MISS_W  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  hit_judge_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W), .MISS_W(MISS_W)) jif ();

  hit_judge #(
    .COORD_W       (COORD_W),
    .SCORE_W       (SCORE_W),
    .HIT_RADIUS    (1),
    .TIMEOUT_CYCLES(16),
    .MAX_MISSES    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .jif  (jif.slave)
  );

  typedef struct {
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               exp_hit;
    int                 exp_score;
    int                 exp_misses;
    logic               exp_over;
  } vec_t;

  vec_t vecs [8];
  bit   exp_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result_valid"}, int'(jif.result_valid), 0);
    check({tag, "_hit"},          int'(jif.hit),          0);
    check({tag, "_score"},        int'(jif.score),        0);
    check({tag, "_misses"},       int'(jif.misses),       0);
    check({tag, "_round_active"}, int'(jif.round_active), 0);
    check({tag, "_game_over"},    int'(jif.game_over),    0);
  endtask

  task automatic set_pos(input int tx, input int ty, input int cx, input int cy);
    jif.target_x = COORD_W'(tx);
    jif.target_y = COORD_W'(ty);
    jif.cursor_x = COORD_W'(cx);
    jif.cursor_y = COORD_W'(cy);
  endtask

  // Every result pulse must match a pending judgment; a pulse lasting two
  // cycles shows up as an unexpected second result.
  always @(negedge clk) begin
    if (jif.result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: result_valid=1 with no judgment pending (hit=%0d)",
                 jif.hit);
      end else begin
        check("result_hit", int'(jif.hit), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    //           tx     ty     cx     cy    hit  score miss over
    vecs[0] = '{5'd0,  5'd0,  5'd1,  5'd1,  1'b1, 1, 0, 1'b0}; // diagonal edge of radius
    vecs[1] = '{5'd10, 5'd10, 5'd11, 5'd9,  1'b1, 2, 0, 1'b0};
    vecs[2] = '{5'd10, 5'd10, 5'd12, 5'd10, 1'b0, 2, 1, 1'b0}; // dx=2
    vecs[3] = '{5'd0,  5'd0,  5'd31, 5'd31, 1'b0, 2, 2, 1'b0}; // no wrap-around
    vecs[4] = '{5'd31, 5'd31, 5'd30, 5'd30, 1'b1, 3, 2, 1'b0};
    vecs[5] = '{5'd20, 5'd3,  5'd21, 5'd4,  1'b1, 3, 2, 1'b0}; // 4th hit saturates
    vecs[6] = '{5'd7,  5'd7,  5'd7,  5'd7,  1'b1, 3, 2, 1'b0};
    vecs[7] = '{5'd3,  5'd20, 5'd3,  5'd22, 1'b0, 3, 3, 1'b1}; // 3rd miss ends game

    jif.fire = 1'b0;
    set_pos(0, 0, 0, 0);

    // Reset held for 5 cycles, then released.
    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_all_zero("reset");

    // Fire from IDLE: SETTLE then ARMED, no result.
    jif.fire = 1'b1;
    tick();
    jif.fire = 1'b0;
    check("idle_fire_settle_round_active", int'(jif.round_active), 0);
    tick();
    check("idle_fire_armed_round_active", int'(jif.round_active), 1);

    // Table-driven rounds, each fired in ARMED timer 0.
    for (int i = 0; i < 8; i++) begin
      set_pos(vecs[i].tx, vecs[i].ty, vecs[i].cx, vecs[i].cy);
      jif.fire = 1'b1;
      exp_q.push_back(vecs[i].exp_hit);
      tick();
      check($sformatf("vec%0d_result_valid", i), int'(jif.result_valid), 1);
      jif.fire = 1'b0;
      tick();
      check($sformatf("vec%0d_result_cleared", i), int'(jif.result_valid), 0);
      check($sformatf("vec%0d_score", i),     int'(jif.score),     vecs[i].exp_score);
      check($sformatf("vec%0d_misses", i),    int'(jif.misses),    vecs[i].exp_misses);
      check($sformatf("vec%0d_game_over", i), int'(jif.game_over), int'(vecs[i].exp_over));
      if (!vecs[i].exp_over) begin
        tick();
        check($sformatf("vec%0d_rearmed", i), int'(jif.round_active), 1);
      end
    end

    // Game over holds with no further results.
    repeat (5) tick();
    check("over_hold_game_over",    int'(jif.game_over),    1);
    check("over_hold_round_active", int'(jif.round_active), 0);
    check("over_hold_score",        int'(jif.score),        3);
    check("over_hold_misses",       int'(jif.misses),       3);

    // Restart from OVER clears counters, no result pulse.
    jif.fire = 1'b1;
    tick();
    jif.fire = 1'b0;
    check("restart_score",     int'(jif.score),     0);
    check("restart_misses",    int'(jif.misses),    0);
    check("restart_game_over", int'(jif.game_over), 0);
    tick();
    check("restart_round_active", int'(jif.round_active), 1);

    // Timeout: no fire for 16 ARMED cycles (now in ARMED timer 0).
    exp_q.push_back(1'b0);
    repeat (15) tick();
    check("timeout_not_early", int'(jif.result_valid), 0);
    tick();
    check("timeout_result_valid", int'(jif.result_valid), 1);
    tick();
    check("timeout_misses", int'(jif.misses), 1);
    tick();
    check("timeout_rearmed", int'(jif.round_active), 1);

    // Fire at timer 15 beats the timeout and is judged by position.
    repeat (15) tick();
    set_pos(9, 9, 10, 10);
    jif.fire = 1'b1;
    exp_q.push_back(1'b1);
    tick();
    check("fire_t15_result_valid", int'(jif.result_valid), 1);
    jif.fire = 1'b0;
    tick();
    check("fire_t15_score",  int'(jif.score),  1);
    check("fire_t15_misses", int'(jif.misses), 1);
    tick();

    // Fire held high across rounds gives exactly one judgment.
    set_pos(4, 4, 4, 5);
    jif.fire = 1'b1;
    exp_q.push_back(1'b1);
    repeat (6) tick();
    jif.fire = 1'b0;
    check("held_fire_score",        int'(jif.score),        2);
    check("held_fire_round_active", int'(jif.round_active), 1);

    // Now ARMED timer 3; let it time out, then raise fire during RESULT.
    exp_q.push_back(1'b0);
    repeat (13) tick();
    check("result_fire_valid", int'(jif.result_valid), 1);
    jif.fire = 1'b1;
    tick();
    jif.fire = 1'b0;
    check("result_fire_misses", int'(jif.misses), 2);
    tick();
    check("result_fire_rearmed", int'(jif.round_active), 1);

    // Reset asserted in ARMED with the timer at 8.
    repeat (8) tick();
    reset = 1'b0;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", int'(jif.round_active), 0);

    check("pending_results", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
